// File: rtl/time_set_controller_if.sv
// Board-facing signal bundle for the time-set controller: button inputs and
// the time/status outputs. The clock and reset stay plain ports on the module.
interface time_set_controller_if;
    logic       modeButton;
    logic       incButton;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       pm;
    logic [1:0] setMode;
    logic       blink;
    logic       secondTick;
    logic       minuteTick;
    logic       hourTick;

    modport master (
        output modeButton, incButton,
        input  hours, minutes, seconds, pm, setMode, blink,
        input  secondTick, minuteTick, hourTick
    );

    modport slave (
        input  modeButton, incButton,
        output hours, minutes, seconds, pm, setMode, blink,
        output secondTick, minuteTick, hourTick
    );
endinterface

// File: rtl/time_set_controller.sv
// Clock with a RUN / SET_HOUR / SET_MINUTE setting FSM driven by two buttons.
// Define TWELVE_HOUR_EN for a 1..12 hour range with a pm flag; default is 0..23.
module time_set_controller #(
    parameter int unsigned CLOCK_HZ = 100000000
) (
    input logic                  cmosClock,
    input logic                  resetN,
    time_set_controller_if.slave bus
);

    localparam int unsigned     PW       = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
    localparam logic [PW-1:0]   PRE_MAX  = PW'(CLOCK_HZ - 1);
    localparam logic [PW-1:0]   PRE_HALF = PW'(CLOCK_HZ / 2);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        SET_HOUR   = 2'b01,
        SET_MINUTE = 2'b10
    } state_e;

    state_e        state_q;
    logic [PW-1:0] presc_q;
    logic [4:0]    hours_q;
    logic [5:0]    minutes_q;
    logic [5:0]    seconds_q;
    logic          blink_q;
    logic          secondTick_q;
    logic          minuteTick_q;
    logic          hourTick_q;
    // [0],[1] synchronise, [2] holds the previous synchronised level
    logic [2:0]    mode_sync_q;
    logic [2:0]    inc_sync_q;

    logic          mode_ev;
    logic          inc_ev;
    logic          sec_wrap;
    logic [4:0]    hours_inc_d;
    logic          pm_toggle_d;

    assign mode_ev  = mode_sync_q[1] & ~mode_sync_q[2];
    assign inc_ev   = inc_sync_q[1] & ~inc_sync_q[2];
    assign sec_wrap = (presc_q == PRE_MAX);

`ifdef TWELVE_HOUR_EN
    localparam logic [4:0] HOUR_RST = 5'd12;
    logic pm_q;

    always_comb begin
        hours_inc_d = (hours_q == 5'd12) ? 5'd1 : hours_q + 5'd1;
        pm_toggle_d = (hours_q == 5'd11);
    end

    assign bus.pm = pm_q;
`else
    localparam logic [4:0] HOUR_RST = 5'd0;

    always_comb begin
        hours_inc_d = (hours_q == 5'd23) ? '0 : hours_q + 5'd1;
        pm_toggle_d = 1'b0;
    end

    assign bus.pm = 1'b0;
`endif

    always_ff @(posedge cmosClock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= RUN;
            presc_q      <= '0;
            hours_q      <= HOUR_RST;
            minutes_q    <= '0;
            seconds_q    <= '0;
            blink_q      <= 1'b0;
            secondTick_q <= 1'b0;
            minuteTick_q <= 1'b0;
            hourTick_q   <= 1'b0;
            mode_sync_q  <= '0;
            inc_sync_q   <= '0;
`ifdef TWELVE_HOUR_EN
            pm_q         <= 1'b0;
`endif
        end else begin
            mode_sync_q  <= {mode_sync_q[1:0], bus.modeButton};
            inc_sync_q   <= {inc_sync_q[1:0], bus.incButton};
            presc_q      <= sec_wrap ? '0 : presc_q + 1'b1;
            blink_q      <= (state_q != RUN) && (presc_q < PRE_HALF);
            secondTick_q <= (state_q == RUN) && sec_wrap;
            minuteTick_q <= 1'b0;
            hourTick_q   <= 1'b0;

            unique case (state_q)
                RUN: begin
                    if (mode_ev) begin
                        state_q   <= SET_HOUR;
                        seconds_q <= '0;
                    end else if (sec_wrap) begin
                        if (seconds_q == 6'd59) begin
                            seconds_q    <= '0;
                            minuteTick_q <= 1'b1;
                            if (minutes_q == 6'd59) begin
                                minutes_q  <= '0;
                                hourTick_q <= 1'b1;
                                hours_q    <= hours_inc_d;
`ifdef TWELVE_HOUR_EN
                                pm_q       <= pm_q ^ pm_toggle_d;
`endif
                            end else begin
                                minutes_q <= minutes_q + 6'd1;
                            end
                        end else begin
                            seconds_q <= seconds_q + 6'd1;
                        end
                    end
                end
                // mode wins over a coincident inc, which is simply dropped
                SET_HOUR: begin
                    if (mode_ev) begin
                        state_q <= SET_MINUTE;
                    end else if (inc_ev) begin
                        hours_q <= hours_inc_d;
`ifdef TWELVE_HOUR_EN
                        pm_q    <= pm_q ^ pm_toggle_d;
`endif
                    end
                end
                SET_MINUTE: begin
                    if (mode_ev) begin
                        state_q <= RUN;
                    end else if (inc_ev) begin
                        minutes_q <= (minutes_q == 6'd59) ? '0 : minutes_q + 6'd1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.hours      = hours_q;
    assign bus.minutes    = minutes_q;
    assign bus.seconds    = seconds_q;
    assign bus.setMode    = state_q;
    assign bus.blink      = blink_q;
    assign bus.secondTick = secondTick_q;
    assign bus.minuteTick = minuteTick_q;
    assign bus.hourTick   = hourTick_q;

endmodule

// File: doc/time_set_controller.md
TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 100000000: number of cmosClock cycles per second; legal values are >= 4 and even.
REQ-002 SHALL have port cmosClock, input, 1 bit: 100 MHz oscillator, the only clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port modeButton, input, 1 bit: asynchronous level from the board button; a rising edge advances the set mode.
REQ-005 SHALL have port incButton, input, 1 bit: asynchronous level from the board button; a rising edge increments the field being set.
REQ-006 SHALL have port hours, output, 5 bits: current hour.
REQ-007 SHALL have port minutes, output, 6 bits: current minute, 0..59.
REQ-008 SHALL have port seconds, output, 6 bits: current second, 0..59.
REQ-009 SHALL have port pm, output, 1 bit: afternoon flag; it is used only in 12-hour builds.
REQ-010 SHALL have port setMode, output, 2 bits: 00 = RUN, 01 = SET_HOUR, 10 = SET_MINUTE.
REQ-011 SHALL have port blink, output, 1 bit: display blink enable for the field being set.
REQ-012 SHALL have ports secondTick, minuteTick and hourTick, outputs, 1 bit each: single-cycle strobes.

Function
REQ-013 SHALL run a prescaler that counts 0..CLOCK_HZ-1 continuously in every state and wraps to 0.
REQ-014 SHALL register secondTick high for exactly one cycle, in the cycle after the prescaler equals CLOCK_HZ-1, and only when in RUN.
REQ-015 SHALL synchronise each button through two flops and then rising-edge detect it; a held button gives exactly one event.
REQ-016 SHALL make the effect of a button event visible on the outputs at the third rising edge of cmosClock after the input goes high.
REQ-017 SHALL implement the FSM RUN -mode-> SET_HOUR -mode-> SET_MINUTE -mode-> RUN; with no mode event the state is held.
REQ-018 SHALL, in RUN and on each second event, increment seconds as follows:
- 59 -> 0, plus a minute carry;
- minutes 59 -> 0, plus an hour carry;
- hours 23 -> 0;
- 23:59:59 -> 00:00:00 in a single update.
REQ-019 SHALL pulse minuteTick together with every minute carry and hourTick together with every hour carry, each for one cycle, aligned with the updated outputs.
REQ-020 SHALL, on entering SET_HOUR from RUN, clear seconds to 0 and hold seconds at 0 throughout both SET states.
REQ-021 SHALL, on an inc event in SET_HOUR, increment hours 23 -> 0 with no other field changing.
REQ-022 SHALL, on an inc event in SET_MINUTE, increment minutes 59 -> 0 with no carry into hours.
REQ-023 SHALL ignore inc events in RUN.
REQ-024 SHALL, when mode and inc events occur in the same cycle, act on mode only and discard inc.
REQ-025 SHALL register blink as 1 while in a SET state and prescaler < CLOCK_HZ/2, and as 0 otherwise.
REQ-026 SHALL keep time counting in RUN regardless of button activity; no second event is lost or duplicated.

Reset
REQ-027 SHALL, while resetN is low, force all of the following immediately and independently of the clock:
- state to RUN;
- prescaler to 0;
- hours, minutes and seconds to 0;
- pm to 0;
- blink to 0;
- all ticks to 0;
- synchroniser and edge flops to 0.
REQ-028 SHALL, when reset is asserted mid-operation (including in a SET state), abandon the state and discard any pending button event.
REQ-029 SHALL produce the first secondTick CLOCK_HZ cycles after reset release.

Configuration
REQ-030 SHALL, when macro TWELVE_HOUR_EN is defined, operate hours in the range 1..12 as follows:
- reset value is 12 with pm = 0;
- 11 -> 12 toggles pm;
- 12 -> 1 does not toggle pm;
- these rules apply both to run carries and to SET_HOUR increments.
REQ-031 SHALL, when TWELVE_HOUR_EN is undefined, operate hours in the range 0..23 and tie pm to 0.

Verification (CLOCK_HZ = 10)
REQ-032 SHALL check reset release: secondTick is first asserted 10 cycles later and seconds = 1 after it; blink = 0 throughout.
REQ-033 SHALL check preload 23:59:59 then wait one secondTick: outputs are 00:00:00, and minuteTick and hourTick pulse in the same cycle.
REQ-034 SHALL check mode event then inc event x3: setMode = 01, hours 0 -> 3 and seconds = 0; with a held incButton, exactly one increment.
REQ-035 SHALL check SET_MINUTE at minutes 59 with one inc event: minutes = 0 and hours unchanged; a further mode event gives setMode = 00 and counting resumes.
REQ-036 SHALL check mode and inc rising in the same cycle while in SET_HOUR: setMode = 10 and hours unchanged.
REQ-037 SHALL check that with TWELVE_HOUR_EN, 11:59:59 pm = 0 followed by one second gives 12:00:00 pm = 1, and that resetN low in SET_MINUTE gives 12:00:00, pm = 0, setMode = 00.
